// File: rtl/edge_gen.sv
// edge_gen: drives a single registered line `a` to a commanded level and
// then holds it for a programmable number of extra cycles before the next
// command may be taken. A command asking for the level already on `a` is
// rejected with a one-cycle err pulse.
//
// Optional feature: define EDGE_GEN_ECHO_EN to add the rise_o / down_o
// echo pulses, which mark the first cycle a shows a command-driven new level.
module edge_gen #(
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   HOLD_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [HOLD_W-1:0] req_hold,
  output logic              a,
  output logic              busy,
  output logic              err
`ifdef EDGE_GEN_ECHO_EN
  ,
  output logic              rise_o,
  output logic              down_o
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_r;
  logic [HOLD_W-1:0] cnt_r;
  logic              a_r;
  logic              err_r;
  logic              rise_r;
  logic              down_r;
  logic              accept_s;
  logic              same_s;

  // Handshake decode: ready only in IDLE and never while reset is applied.
  always_comb begin
    req_ready = 1'b0;
    accept_s  = 1'b0;
    same_s    = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      req_ready = 1'b1;
      accept_s  = req_valid;
      same_s    = (req_dir == a_r);
    end else begin
      req_ready = 1'b0;
      accept_s  = 1'b0;
      same_s    = 1'b0;
    end
  end

  // Command FSM: level update, hold countdown, error and echo pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {HOLD_W{1'b0}};
      a_r     <= IDLE_LEVEL;
      err_r   <= 1'b0;
      rise_r  <= 1'b0;
      down_r  <= 1'b0;
    end else begin
      err_r  <= 1'b0;
      rise_r <= 1'b0;
      down_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (same_s) begin
              // Level already present: flag it, keep level, ignore hold.
              err_r <= 1'b1;
            end else begin
              a_r    <= req_dir;
              rise_r <= req_dir;
              down_r <= ~req_dir;
              if (req_hold != {HOLD_W{1'b0}}) begin
                cnt_r   <= req_hold;
                state_r <= HOLD;
              end else begin
                state_r <= IDLE;
              end
            end
          end else begin
            state_r <= IDLE;
          end
        end
        HOLD: begin
          // The <= 1 test also covers an impossible zero count, so the
          // counter can never wrap below zero.
          if (cnt_r <= {{(HOLD_W-1){1'b0}}, 1'b1}) begin
            cnt_r   <= {HOLD_W{1'b0}};
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r - {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {HOLD_W{1'b0}};
        end
      endcase
    end
  end

  assign a    = a_r;
  assign busy = (state_r == HOLD);
  assign err  = err_r;

`ifdef EDGE_GEN_ECHO_EN
  assign rise_o = rise_r;
  assign down_o = down_r;
`endif

endmodule

// File: tb/tb_edge_gen.sv
// Bench for edge_gen: each scenario queues per-cycle stimulus together with
// the outputs expected after that clock edge, then replays the queue and
// compares the DUT against each popped entry.
module tb_edge_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_dir = 1'b0;
  logic [7:0] req_hold = 8'd0;
  logic       a;
  logic       busy;
  logic       err;
`ifdef EDGE_GEN_ECHO_EN
  logic       rise_o;
  logic       down_o;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       v;
    logic       dir;
    logic [7:0] hold;
    logic [3:0] exp_main;  // {a, req_ready, busy, err}
    logic [1:0] exp_echo;  // {rise_o, down_o}
    string      tag;
  } row_t;

  row_t sb_q[$];

  edge_gen dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_dir(req_dir),
    .req_hold(req_hold),
    .a(a),
    .busy(busy),
    .err(err)
`ifdef EDGE_GEN_ECHO_EN
    ,
    .rise_o(rise_o),
    .down_o(down_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic push(input logic r, input logic v, input logic dir, input logic [7:0] hold,
                      input logic ea, input logic er, input logic eb, input logic ee,
                      input logic eru, input logic edn, input string tag);
    row_t x;
    x.rst = r; x.v = v; x.dir = dir; x.hold = hold;
    x.exp_main = {ea, er, eb, ee};
    x.exp_echo = {eru, edn};
    x.tag = tag;
    sb_q.push_back(x);
  endtask

  task automatic test_reset();
    row_t c;
    // Reset for two cycles with a fall offered: it must not be taken.
    push(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_c0");
    push(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_c1");
    push(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_rel");
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      rst = c.rst; req_valid = c.v; req_dir = c.dir; req_hold = c.hold;
      @(posedge clk); #1;
      total++;
      if ({a, req_ready, busy, err} !== c.exp_main) begin
        bad++;
        $display("FAIL reset/%s: got {a,rdy,busy,err}=%b want %b", c.tag, {a, req_ready, busy, err}, c.exp_main);
      end
`ifdef EDGE_GEN_ECHO_EN
      total++;
      if ({rise_o, down_o} !== c.exp_echo) begin
        bad++;
        $display("FAIL reset_echo/%s: got {rise,down}=%b want %b", c.tag, {rise_o, down_o}, c.exp_echo);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    row_t c;
    push(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "fall_h0");
    push(1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "rise_h0");
    push(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      rst = c.rst; req_valid = c.v; req_dir = c.dir; req_hold = c.hold;
      @(posedge clk); #1;
      total++;
      if ({a, req_ready, busy, err} !== c.exp_main) begin
        bad++;
        $display("FAIL b2b/%s: got {a,rdy,busy,err}=%b want %b", c.tag, {a, req_ready, busy, err}, c.exp_main);
      end
`ifdef EDGE_GEN_ECHO_EN
      total++;
      if ({rise_o, down_o} !== c.exp_echo) begin
        bad++;
        $display("FAIL b2b_echo/%s: got {rise,down}=%b want %b", c.tag, {rise_o, down_o}, c.exp_echo);
      end
`endif
    end
  endtask

  task automatic test_hold3();
    row_t c;
    // Fall with hold 3, then a rise held valid throughout the hold.
    push(1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "fall_h3");
    push(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "hold_1");
    push(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "hold_2");
    push(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "hold_end");
    push(1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "rise_acc");
    push(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      rst = c.rst; req_valid = c.v; req_dir = c.dir; req_hold = c.hold;
      @(posedge clk); #1;
      total++;
      if ({a, req_ready, busy, err} !== c.exp_main) begin
        bad++;
        $display("FAIL hold3/%s: got {a,rdy,busy,err}=%b want %b", c.tag, {a, req_ready, busy, err}, c.exp_main);
      end
`ifdef EDGE_GEN_ECHO_EN
      total++;
      if ({rise_o, down_o} !== c.exp_echo) begin
        bad++;
        $display("FAIL hold3_echo/%s: got {rise,down}=%b want %b", c.tag, {rise_o, down_o}, c.exp_echo);
      end
`endif
    end
  endtask

  task automatic test_err();
    row_t c;
    push(1'b0, 1'b1, 1'b1, 8'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "err_rise");
    push(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "fall_next");
    push(1'b0, 1'b1, 1'b0, 8'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "err_fall");
    push(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "err_clr");
    push(1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "rise");
    push(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      rst = c.rst; req_valid = c.v; req_dir = c.dir; req_hold = c.hold;
      @(posedge clk); #1;
      total++;
      if ({a, req_ready, busy, err} !== c.exp_main) begin
        bad++;
        $display("FAIL err/%s: got {a,rdy,busy,err}=%b want %b", c.tag, {a, req_ready, busy, err}, c.exp_main);
      end
`ifdef EDGE_GEN_ECHO_EN
      total++;
      if ({rise_o, down_o} !== c.exp_echo) begin
        bad++;
        $display("FAIL err_echo/%s: got {rise,down}=%b want %b", c.tag, {rise_o, down_o}, c.exp_echo);
      end
`endif
    end
  endtask

  task automatic test_reset_in_hold();
    row_t c;
    push(1'b0, 1'b1, 1'b0, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "fall_h255");
    for (int i = 1; i < 10; i++)
      push(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "in_hold");
    push(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_abort");
    push(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      rst = c.rst; req_valid = c.v; req_dir = c.dir; req_hold = c.hold;
      @(posedge clk); #1;
      total++;
      if ({a, req_ready, busy, err} !== c.exp_main) begin
        bad++;
        $display("FAIL rst_hold/%s: got {a,rdy,busy,err}=%b want %b", c.tag, {a, req_ready, busy, err}, c.exp_main);
      end
`ifdef EDGE_GEN_ECHO_EN
      total++;
      if ({rise_o, down_o} !== c.exp_echo) begin
        bad++;
        $display("FAIL rst_hold_echo/%s: got {rise,down}=%b want %b", c.tag, {rise_o, down_o}, c.exp_echo);
      end
`endif
    end
  endtask

  task automatic test_max_hold();
    row_t c;
    // Full 255 countdown with a rise held valid; ignored inputs vary.
    push(1'b0, 1'b1, 1'b0, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "fall_max");
    for (int i = 1; i < 255; i++)
      push(1'b0, 1'b1, i[0], i[7:0], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "max_hold");
    push(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "max_end");
    push(1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "max_rise");
    push(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      rst = c.rst; req_valid = c.v; req_dir = c.dir; req_hold = c.hold;
      @(posedge clk); #1;
      total++;
      if ({a, req_ready, busy, err} !== c.exp_main) begin
        bad++;
        $display("FAIL max_hold/%s: got {a,rdy,busy,err}=%b want %b", c.tag, {a, req_ready, busy, err}, c.exp_main);
      end
`ifdef EDGE_GEN_ECHO_EN
      total++;
      if ({rise_o, down_o} !== c.exp_echo) begin
        bad++;
        $display("FAIL max_hold_echo/%s: got {rise,down}=%b want %b", c.tag, {rise_o, down_o}, c.exp_echo);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold3();
    test_err();
    test_reset_in_hold();
    test_max_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_gen.md
EDGE_GEN -- requirements
Module: edge_gen

Interface
REQ-001 The block SHALL have parameter IDLE_LEVEL, default 1'b1: the level of output a after reset.
REQ-002 The block SHALL have parameter HOLD_W, default 8: the width of req_hold and of the hold counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a command is offered.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a command this cycle.
REQ-007 The block SHALL have port req_dir, input, 1 bit: requested edge, where 1 means rise (a goes 1) and 0 means fall (a goes 0).
REQ-008 The block SHALL have port req_hold, input, HOLD_W bits: extra cycles the new level is held before the next command is accepted.
REQ-009 The block SHALL have port a, output, 1 bit: the registered generated line.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in HOLD.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse when an accepted command requests the level already on a.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and HOLD; busy = (state == HOLD).
REQ-013 req_ready SHALL equal (state == IDLE) && !rst, combinationally.
REQ-014 A command SHALL be accepted on a rising edge where req_valid && req_ready; no other cycle accepts.
REQ-015 On acceptance with req_dir != a, a SHALL take req_dir at that same edge, i.e. visible the following cycle.
REQ-016 On acceptance with req_dir != a and req_hold == 0, the state SHALL remain IDLE, so the next command can be accepted on the next edge.
REQ-017 On acceptance with req_dir != a and req_hold == N > 0, the counter SHALL load N and the state SHALL go to HOLD.
REQ-018 In HOLD the counter SHALL decrement each cycle; on the edge where it is 1 it SHALL reach 0 and the state SHALL return to IDLE.
REQ-019 A level produced by a command with hold N SHALL therefore persist at least N+1 cycles, and req_ready SHALL be low for exactly N cycles after acceptance.
REQ-020 On acceptance with req_dir == a, a SHALL be unchanged, err SHALL pulse high for exactly one cycle, the state SHALL remain IDLE, and req_hold SHALL be ignored.
REQ-021 err SHALL be 0 in every cycle not covered by REQ-020.
REQ-022 In HOLD, req_valid, req_dir and req_hold SHALL be ignored; a held-high req_valid SHALL be accepted on the first edge after the return to IDLE.
REQ-023 The counter SHALL never wrap: a load of 2^HOLD_W-1 SHALL count down to 0 and stop.

Reset
REQ-024 On a rising edge with rst=1: a=IDLE_LEVEL, state=IDLE, counter=0, err=0, echo outputs (if present)=0.
REQ-025 While rst=1, req_ready SHALL be 0 and no command SHALL be accepted.
REQ-026 Reset asserted during HOLD SHALL abort the hold; a SHALL return to IDLE_LEVEL at that edge even if this produces an edge.

Configuration
REQ-027 With macro EDGE_GEN_ECHO_EN defined, outputs rise_o and down_o (1 bit each) SHALL exist.
REQ-028 With EDGE_GEN_ECHO_EN defined, rise_o SHALL pulse one cycle, coincident with the cycle a first shows 1 after a command-driven 0->1 change; down_o likewise for 1->0; neither SHALL pulse on reset-induced changes or on err commands.
REQ-029 Without EDGE_GEN_ECHO_EN, rise_o and down_o SHALL be absent from the port list, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset is held for 2 cycles, then released, with IDLE_LEVEL=1 -> a=1, req_ready=1, busy=0, err=0.
REQ-031 Fall with hold=0 is accepted at edge k -> a=0 from cycle k+1; a rise offered at k+1 is accepted there, and a=1 from k+2.
REQ-032 Fall with hold=3 is accepted at edge k, with req_valid held high and a rise command pending -> req_ready=0 for cycles k+1..k+3, the rise is accepted at k+4, and a=0 for exactly 4 cycles.
REQ-033 Rise is requested while a=1 -> err=1 for exactly one cycle, a stays 1, busy stays 0, and the next command is accepted the following edge.
REQ-034 Fall with hold=255 (HOLD_W=8), then rst=1 asserted 10 cycles later -> a=1, busy=0 at the next edge; req_ready=1 the cycle after rst deasserts.
REQ-035 With EDGE_GEN_ECHO_EN, run fall(hold=2) then rise(hold=0) -> down_o pulses once in the cycle a first reads 0, rise_o pulses once in the cycle a first reads 1, and there are no pulses at reset.
